mapper_irq_unit: RTL and testbench
==================================

// Module: mapper_irq_unit
// PURPOSE
//  Parametrised mapper IRQ generator. It is the successor to the single-mode
//  MMC5 scanline-compare IRQ, and it is shared by MMC5/MMC3/FME-7-class mappers.
//  One instance supports three selectable sources:
//   - scanline compare
//   - filtered CHR A12 edge counter
//   - CPU-cycle down-counter
//  It sits beside the mapper's register decode and drives the mapper's irq output.
// PARAMETERS
//  CNT_W       16  cycle-counter width (8..16); latch {HI,LO} is truncated/zero-extended to CNT_W
//  A12_FILTER  3   number of consecutive ce cycles chr_a12 must be low before a rise counts (1..15)
//  MMC3_OLD    0   1 = A12 IRQ only on decrement to zero; 0 = also when reloaded with zero
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-high
//  ce            in   1      clock enable; all non-reset state changes are qualified by ce
//  cfg_we        in   1      register write strobe (one ce cycle)
//  cfg_addr      in   3      0 MODE, 1 LATCH_LO, 2 LATCH_HI, 3 RELOAD, 4 ACK
//  cfg_din       in   8      write data
//  irq_ack       in   1      read-clear strobe (e.g. CPU read of status)
//  ppu_scanline  in   9      current PPU scanline (261 = pre-render)
//  ppu_cycle     in   9      current PPU dot 0..340
//  ppu_rendering in   1      background or sprites enabled
//  chr_a12       in   1      PPU CHR address bit 12
//  cpu_tick      in   1      one-ce pulse per CPU cycle
//  irq           out  1      pending & enable
//  irq_pending   out  1      raw pending flag (status readback)
//  in_frame      out  1      rendering visible scanline (status readback)
//  count         out  CNT_W  live counter value (debug/readback)
// BEHAVIOUR
//  Reset: mode=0, enable=0, auto_reload=0, latch=0, count=0, reload_flag=0,
//    filter=0, pending=0, in_frame=0, so irq=0. Async assert clears immediately,
//    including mid-count.
//  MODE write: [1:0] src (0 off, 1 scanline, 2 A12, 3 cycle); [6] auto_reload; [7] enable.
//    Writing enable=0 clears pending in the same cycle.
//  RELOAD write: A12 mode sets reload_flag. Cycle mode loads count<=latch.
//  ACK write or irq_ack: clears pending.
//  Set versus clear in the same ce cycle: set wins.
//  in_frame: registered, = ppu_rendering && ppu_scanline<240; updated every ce.
//  Scanline src: at ppu_cycle==0, if ppu_rendering && LATCH_LO in 1..239 &&
//    ppu_scanline=={0,LATCH_LO}, then pending<=1. One set per frame; latency 1 ce.
//  A12 src:
//    - Filter counter saturates at A12_FILTER while chr_a12=0 and clears when chr_a12=1.
//    - A rise counts only if the filter counter reached A12_FILTER beforehand.
//    - On a counted rise: if count==0 || reload_flag then count<=LATCH_LO and
//      reload_flag<=0; else count<=count-1.
//    - Then, if the new count==0 (MMC3_OLD=1: only via decrement) && enable, pending<=1.
//    - Only count[7:0] is used; upper bits are held at 0.
//  Cycle src: on cpu_tick && enable:
//    - if count==0: pending<=1 and count<=auto_reload ? latch : all-ones;
//    - else count<=count-1.
//  Priority within a ce cycle: reset > cfg write to counter (RELOAD in cycle
//    mode) > tick/edge decrement.
//  Changing src does not clear count or pending.
//  src=0: counters frozen; pending is held.
// STRUCTURE
//  Package mapper_irq_pkg:
//    - SRC_OFF/SRC_SCANLINE/SRC_A12/SRC_CYCLE localparams;
//    - register address constants REG_MODE..REG_ACK;
//    - VISIBLE_LINES=240.
//  Sub-module a12_edge_filter (params A12_FILTER; ports clk, reset, ce, chr_a12 -> edge pulse).
//  Top: register file, source mux, counter, pending flag.
// TESTING
//  1 MODE=0x81, LATCH_LO=0x20, rendering=1, sweep lines -> pending/irq rise at line 32
//    dot 0 (+1 ce); ACK -> irq 0; no second set until next frame.
//  2 MODE=0x82, LATCH_LO=3, RELOAD, 4 filtered A12 rises -> count 3,2,1,0; irq on 4th
//    rise; rise after A12 low for 1 ce (filter 3) -> count unchanged.
//  3 MODE=0x83, latch=0x0005, RELOAD, 6 cpu_ticks -> irq on 6th, count=0xFFFF; MODE=0xC3
//    repeat -> count reloads 0x0005.
//  4 irq_ack in the same ce as the cycle-mode zero tick -> pending remains 1.
//  5 reset asserted asynchronously mid-count (between clk edges) -> irq=0 and count=0
//    before the next clk edge.
//  6 pending=1, write MODE=0x02 -> irq and pending 0 next cycle; count preserved.

Source files
------------

// File: rtl/mapper_irq_pkg.sv
// Shared constants for the mapper IRQ unit: IRQ source encodings, register
// addresses and the visible-scanline bound.
package mapper_irq_pkg;

  // MODE[1:0] source select
  localparam logic [1:0] SRC_OFF      = 2'd0;
  localparam logic [1:0] SRC_SCANLINE = 2'd1;
  localparam logic [1:0] SRC_A12      = 2'd2;
  localparam logic [1:0] SRC_CYCLE    = 2'd3;

  // cfg_addr register map
  localparam logic [2:0] REG_MODE     = 3'd0;
  localparam logic [2:0] REG_LATCH_LO = 3'd1;
  localparam logic [2:0] REG_LATCH_HI = 3'd2;
  localparam logic [2:0] REG_RELOAD   = 3'd3;
  localparam logic [2:0] REG_ACK      = 3'd4;

  localparam logic [8:0] VISIBLE_LINES = 9'd240;

endpackage

// File: rtl/a12_edge_filter.sv
// CHR A12 rising-edge detector with a low-time filter. A rise is reported only
// after chr_a12 has been low for A12_FILTER consecutive ce cycles, which rejects
// the short A12 toggles seen during sprite/background fetch interleaving.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   ce_i            clock enable
//   chr_a12_i       PPU CHR address bit 12
//   rise_o          one-ce pulse on a qualified rising edge
module a12_edge_filter #(
  parameter int unsigned A12_FILTER = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ce_i,
  input  logic chr_a12_i,
  output logic rise_o
);

  localparam logic [3:0] FiltMax = 4'(A12_FILTER);

  logic [3:0] filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    if (ce_i) begin
      if (chr_a12_i) begin
        filt_d = 4'd0;
      end else if (filt_q != FiltMax) begin
        filt_d = filt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      filt_q <= 4'd0;
    end else begin
      filt_q <= filt_d;
    end
  end

  // The counter is cleared whenever A12 is high, so a saturated count already
  // implies the previous sample was low; no separate edge register is needed.
  assign rise_o = ce_i && chr_a12_i && (filt_q == FiltMax);

endmodule

// File: rtl/mapper_irq_unit.sv
// Mapper IRQ generator with three selectable sources: scanline compare,
// filtered CHR A12 edge counter and CPU-cycle down-counter.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   ce_i                  clock enable for all state changes
//   cfg_we_i/addr/din     register write port (MODE, LATCH_LO/HI, RELOAD, ACK)
//   irq_ack_i             read-clear strobe for the pending flag
//   ppu_*_i, chr_a12_i    PPU timing and CHR A12
//   cpu_tick_i            one-ce pulse per CPU cycle
//   irq_o                 pending & enable
//   irq_pending_o         raw pending flag
//   in_frame_o            rendering a visible scanline
//   count_o               live counter value
module mapper_irq_unit
  import mapper_irq_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned A12_FILTER = 3,
  parameter bit          MMC3_OLD   = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_addr_i,
  input  logic [7:0]       cfg_din_i,
  input  logic             irq_ack_i,
  input  logic [8:0]       ppu_scanline_i,
  input  logic [8:0]       ppu_cycle_i,
  input  logic             ppu_rendering_i,
  input  logic             chr_a12_i,
  input  logic             cpu_tick_i,
  output logic             irq_o,
  output logic             irq_pending_o,
  output logic             in_frame_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       src_q, src_d;
  logic             auto_q, auto_d;
  logic             en_q, en_d;
  logic [7:0]       lat_lo_q, lat_lo_d;
  logic [7:0]       lat_hi_q, lat_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic             pend_q, pend_d;
  logic             in_frame_q, in_frame_d;

  logic             a12_rise;
  logic             wr_mode, wr_lo, wr_hi, wr_reload, wr_ack;
  logic             pend_set, pend_clr;
  logic [7:0]       a12_next;
  logic             a12_dec;
  logic [15:0]      latch_full;
  logic [CNT_W-1:0] cnt_latch;
  logic             unused_din;

  a12_edge_filter #(
    .A12_FILTER (A12_FILTER)
  ) u_a12_filter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ce_i      (ce_i),
    .chr_a12_i (chr_a12_i),
    .rise_o    (a12_rise)
  );

  assign wr_mode   = cfg_we_i && (cfg_addr_i == REG_MODE);
  assign wr_lo     = cfg_we_i && (cfg_addr_i == REG_LATCH_LO);
  assign wr_hi     = cfg_we_i && (cfg_addr_i == REG_LATCH_HI);
  assign wr_reload = cfg_we_i && (cfg_addr_i == REG_RELOAD);
  assign wr_ack    = cfg_we_i && (cfg_addr_i == REG_ACK);

  assign latch_full = {lat_hi_q, lat_lo_q};
  assign cnt_latch  = latch_full[CNT_W-1:0];
  assign unused_din = ^cfg_din_i[5:2];

  always_comb begin
    src_d      = src_q;
    auto_d     = auto_q;
    en_d       = en_q;
    lat_lo_d   = lat_lo_q;
    lat_hi_d   = lat_hi_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    pend_d     = pend_q;
    in_frame_d = in_frame_q;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    a12_next   = 8'd0;
    a12_dec    = 1'b0;

    if (ce_i) begin
      in_frame_d = ppu_rendering_i && (ppu_scanline_i < VISIBLE_LINES);

      if (wr_mode) begin
        src_d  = cfg_din_i[1:0];
        auto_d = cfg_din_i[6];
        en_d   = cfg_din_i[7];
        if (!cfg_din_i[7]) pend_clr = 1'b1;
      end
      if (wr_lo) lat_lo_d = cfg_din_i;
      if (wr_hi) lat_hi_d = cfg_din_i;
      if (wr_ack || irq_ack_i) pend_clr = 1'b1;

      unique case (src_q)
        SRC_OFF: begin
        end
        SRC_SCANLINE: begin
          if ((ppu_cycle_i == 9'd0) && ppu_rendering_i && (lat_lo_q != 8'd0) &&
              ({1'b0, lat_lo_q} < VISIBLE_LINES) && (ppu_scanline_i == {1'b0, lat_lo_q})) begin
            pend_set = 1'b1;
          end
        end
        SRC_A12: begin
          if (a12_rise) begin
            if ((cnt_q[7:0] == 8'd0) || reload_q) begin
              a12_next = lat_lo_q;
              reload_d = 1'b0;
            end else begin
              a12_next = cnt_q[7:0] - 8'd1;
              a12_dec  = 1'b1;
            end
            cnt_d      = '0;
            cnt_d[7:0] = a12_next;
            if ((a12_next == 8'd0) && en_q && (!MMC3_OLD || a12_dec)) pend_set = 1'b1;
          end
          // A RELOAD write in the same cycle as an edge re-arms for the next edge
          if (wr_reload) reload_d = 1'b1;
        end
        SRC_CYCLE: begin
          if (wr_reload) begin
            cnt_d = cnt_latch;
          end else if (cpu_tick_i && en_q) begin
            if (cnt_q == '0) begin
              pend_set = 1'b1;
              cnt_d    = auto_q ? cnt_latch : '1;
            end else begin
              cnt_d = cnt_q - CntOne;
            end
          end
        end
      endcase

      if (pend_set) begin
        pend_d = 1'b1;
      end else if (pend_clr) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_q      <= SRC_OFF;
      auto_q     <= 1'b0;
      en_q       <= 1'b0;
      lat_lo_q   <= 8'd0;
      lat_hi_q   <= 8'd0;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      pend_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      src_q      <= src_d;
      auto_q     <= auto_d;
      en_q       <= en_d;
      lat_lo_q   <= lat_lo_d;
      lat_hi_q   <= lat_hi_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      pend_q     <= pend_d;
      in_frame_q <= in_frame_d;
    end
  end

  assign irq_o         = pend_q && en_q;
  assign irq_pending_o = pend_q;
  assign in_frame_o    = in_frame_q;
  assign count_o       = cnt_q;

endmodule

// File: tb/tb_mapper_irq_unit.sv
// Directed bench for mapper_irq_unit: one task per feature, inline checks.
module tb_mapper_irq_unit;
  import mapper_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_din;
  logic        irq_ack;
  logic [8:0]  ppu_scanline;
  logic [8:0]  ppu_cycle;
  logic        ppu_rendering;
  logic        chr_a12;
  logic        cpu_tick;
  logic        irq;
  logic        irq_pending;
  logic        in_frame;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;

  mapper_irq_unit #(
    .CNT_W      (16),
    .A12_FILTER (3),
    .MMC3_OLD   (1'b0)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .ce_i            (ce),
    .cfg_we_i        (cfg_we),
    .cfg_addr_i      (cfg_addr),
    .cfg_din_i       (cfg_din),
    .irq_ack_i       (irq_ack),
    .ppu_scanline_i  (ppu_scanline),
    .ppu_cycle_i     (ppu_cycle),
    .ppu_rendering_i (ppu_rendering),
    .chr_a12_i       (chr_a12),
    .cpu_tick_i      (cpu_tick),
    .irq_o           (irq),
    .irq_pending_o   (irq_pending),
    .in_frame_o      (in_frame),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic ticks(input int n);
    cpu_tick = 1'b1;
    repeat (n) step();
    cpu_tick = 1'b0;
  endtask

  task automatic a12_pulse(input int low_len);
    chr_a12 = 1'b0;
    repeat (low_len) step();
    chr_a12 = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", irq_pending); end
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", count); end
    checks++; if (in_frame !== 1'b0) begin failures++; $display("FAIL reset_in_frame got=%b exp=0", in_frame); end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_scanline();
    logic exp_p;
    logic exp_if;
    int   lim;
    wr(REG_LATCH_LO, 8'h20);
    wr(REG_MODE, 8'h81);
    ppu_rendering = 1'b1;
    exp_p = 1'b0;
    for (int f = 0; f < 2; f++) begin
      lim = (f == 0) ? 262 : 41;
      for (int l = 0; l < lim; l++) begin
        ppu_scanline = 9'(l);
        ppu_cycle = 9'd0;
        step();
        if (l == 32) exp_p = 1'b1;
        exp_if = (l < 240);
        checks++;
        if (irq_pending !== exp_p) begin
          failures++; $display("FAIL scan_pending f=%0d line=%0d got=%b exp=%b", f, l, irq_pending, exp_p);
        end
        checks++;
        if (irq !== exp_p) begin
          failures++; $display("FAIL scan_irq f=%0d line=%0d got=%b exp=%b", f, l, irq, exp_p);
        end
        checks++;
        if (in_frame !== exp_if) begin
          failures++; $display("FAIL scan_in_frame line=%0d got=%b exp=%b", l, in_frame, exp_if);
        end
        ppu_cycle = 9'd1;
        if (f == 0 && l == 33) begin
          wr(REG_ACK, 8'h00);
          exp_p = 1'b0;
          checks++; if (irq !== 1'b0) begin failures++; $display("FAIL scan_ack_irq got=%b exp=0", irq); end
        end else begin
          step();
        end
      end
    end
    wr(REG_MODE, 8'h00);
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL scan_disable_pending got=%b exp=0", irq_pending); end
    ppu_rendering = 1'b0;
  endtask

  task automatic test_a12();
    logic [15:0] exp_c [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    logic        exp_p;
    wr(REG_LATCH_LO, 8'h03);
    wr(REG_MODE, 8'h82);
    wr(REG_RELOAD, 8'h00);
    for (int i = 0; i < 4; i++) begin
      a12_pulse(3);
      exp_p = (i == 3);
      checks++;
      if (count !== exp_c[i]) begin failures++; $display("FAIL a12_count rise=%0d got=%h exp=%h", i, count, exp_c[i]); end
      checks++;
      if (irq !== exp_p) begin failures++; $display("FAIL a12_irq rise=%0d got=%b exp=%b", i, irq, exp_p); end
    end
    a12_pulse(1);
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL a12_filtered_count got=%h exp=0000", count); end
    a12_pulse(2);
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL a12_filtered2_count got=%h exp=0000", count); end
    a12_pulse(3);
    checks++; if (count !== 16'd3) begin failures++; $display("FAIL a12_zero_reload got=%h exp=0003", count); end
    wr(REG_ACK, 8'h00);
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL a12_ack got=%b exp=0", irq_pending); end
    chr_a12 = 1'b0;
    wr(REG_MODE, 8'h00);
  endtask

  task automatic test_cycle();
    logic exp_p;
    wr(REG_LATCH_LO, 8'h05);
    wr(REG_LATCH_HI, 8'h00);
    wr(REG_MODE, 8'h83);
    wr(REG_RELOAD, 8'h00);
    checks++; if (count !== 16'h0005) begin failures++; $display("FAIL cyc_reload got=%h exp=0005", count); end
    for (int i = 1; i <= 6; i++) begin
      ticks(1);
      exp_p = (i == 6);
      checks++;
      if (irq !== exp_p) begin failures++; $display("FAIL cyc_irq tick=%0d got=%b exp=%b", i, irq, exp_p); end
    end
    checks++; if (count !== 16'hFFFF) begin failures++; $display("FAIL cyc_wrap got=%h exp=ffff", count); end
    wr(REG_ACK, 8'h00);
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL cyc_ack got=%b exp=0", irq_pending); end
    wr(REG_MODE, 8'hC3);
    wr(REG_RELOAD, 8'h00);
    ticks(5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cyc_auto_early_irq got=%b exp=0", irq); end
    ticks(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL cyc_auto_irq got=%b exp=1", irq); end
    checks++; if (count !== 16'h0005) begin failures++; $display("FAIL cyc_auto_count got=%h exp=0005", count); end
    wr(REG_ACK, 8'h00);
    wr(REG_LATCH_HI, 8'hA5);
    wr(REG_LATCH_LO, 8'h5A);
    wr(REG_RELOAD, 8'h00);
    checks++; if (count !== 16'hA55A) begin failures++; $display("FAIL cyc_latch16 got=%h exp=a55a", count); end
    wr(REG_LATCH_HI, 8'h00);
  endtask

  task automatic test_ack_collision();
    wr(REG_LATCH_LO, 8'h01);
    wr(REG_RELOAD, 8'h00);
    ticks(1);
    checks++; if (count !== 16'h0000 || irq_pending !== 1'b0) begin
      failures++; $display("FAIL coll_pre count=%h pend=%b exp count=0000 pend=0", count, irq_pending);
    end
    cpu_tick = 1'b1; irq_ack = 1'b1;
    step();
    cpu_tick = 1'b0; irq_ack = 1'b0;
    checks++; if (irq_pending !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", irq_pending); end
    checks++; if (count !== 16'h0001) begin failures++; $display("FAIL coll_count got=%h exp=0001", count); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL coll_irq_ack got=%b exp=0", irq_pending); end
  endtask

  task automatic test_async_reset();
    wr(REG_LATCH_LO, 8'h03);
    wr(REG_RELOAD, 8'h00);
    ticks(5);
    checks++; if (irq !== 1'b1 || count !== 16'h0002) begin
      failures++; $display("FAIL arst_pre irq=%b count=%h exp irq=1 count=0002", irq, count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL arst_count got=%h exp=0000", count); end
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL arst_pending got=%b exp=0", irq_pending); end
    step();
    reset = 1'b0;
    step();
    ticks(2);
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL arst_mode_off got=%h exp=0000", count); end
  endtask

  task automatic test_mode_clear();
    wr(REG_LATCH_LO, 8'h02);
    wr(REG_MODE, 8'h83);
    wr(REG_RELOAD, 8'h00);
    ticks(3);
    checks++; if (irq_pending !== 1'b1 || irq !== 1'b1) begin
      failures++; $display("FAIL mclr_pre pend=%b irq=%b exp 1 1", irq_pending, irq);
    end
    wr(REG_MODE, 8'h02);
    checks++; if (irq_pending !== 1'b0) begin failures++; $display("FAIL mclr_pending got=%b exp=0", irq_pending); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mclr_irq got=%b exp=0", irq); end
    checks++; if (count !== 16'hFFFF) begin failures++; $display("FAIL mclr_count got=%h exp=ffff", count); end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_din = 8'd0;
    irq_ack = 1'b0; ppu_scanline = 9'd0; ppu_cycle = 9'd5; ppu_rendering = 1'b0;
    chr_a12 = 1'b0; cpu_tick = 1'b0;
    test_reset();
    test_scanline();
    test_a12();
    test_cycle();
    test_ack_collision();
    test_async_reset();
    test_mode_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
